// File: rtl/alu_seq_if.sv
// Handshake/operand bundle between the execute-stage control FSM and the ALU.
// The master drives requests and operands; the slave (ALU) returns result and status.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, alu_op, a, b,
    input  result, zero, busy, done, div_zero
  );

  modport slave (
    input  start, alu_op, a, b,
    output result, zero, busy, done, div_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle arithmetic/logic ops
// and WIDTH-iteration shift-add multiply and restoring unsigned divide.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SHW-1:0]   cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;

  logic             accept_s;
  logic             is_div_s;
  logic             b_zero_s;
  logic             go_calc_s;
  logic             last_s;
  logic [WIDTH-1:0] imm_res_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   shifted_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic [WIDTH-1:0] iter_res_s;

  // Request decode and next-state selection.
  always_comb begin
    accept_s    = 1'b0;
    is_div_s    = 1'b0;
    b_zero_s    = 1'b0;
    go_calc_s   = 1'b0;
    last_s      = 1'b0;
    state_nxt_s = state_r;
    accept_s    = (state_r == ST_IDLE) && bus.start;
    is_div_s    = (bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU);
    b_zero_s    = (bus.b == {WIDTH{1'b0}});
    go_calc_s   = (bus.alu_op == OP_MUL) || (is_div_s && !b_zero_s);
    last_s      = (cnt_r == CNT_LAST);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (go_calc_s) begin
            state_nxt_s = ST_CALC;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Single-cycle result, including the divide-by-zero shortcut values.
  always_comb begin
    imm_res_s = {WIDTH{1'b0}};
    case (bus.alu_op)
      OP_ADD:  imm_res_s = bus.a + bus.b;
      OP_SUB:  imm_res_s = bus.a - bus.b;
      OP_AND:  imm_res_s = bus.a & bus.b;
      OP_OR:   imm_res_s = bus.a | bus.b;
      OP_XOR:  imm_res_s = bus.a ^ bus.b;
      OP_SLT:  imm_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL:  imm_res_s = bus.a << bus.b[SHW-1:0];
      OP_SRL:  imm_res_s = bus.a >> bus.b[SHW-1:0];
      OP_SRA:  imm_res_s = $unsigned($signed(bus.a) >>> bus.b[SHW-1:0]);
      OP_DIVU: imm_res_s = {WIDTH{1'b1}};
      OP_REMU: imm_res_s = bus.a;
      default: imm_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration step: shift-add for MUL, restoring trial subtract for DIVU/REMU.
  always_comb begin
    mul_acc_s  = acc_r;
    shifted_s  = {acc_r, a_r[WIDTH-1]};
    ge_s       = (shifted_s >= {1'b0, b_r});
    rem_nxt_s  = shifted_s[WIDTH-1:0];
    quo_nxt_s  = {a_r[WIDTH-2:0], ge_s};
    iter_res_s = {WIDTH{1'b0}};
    if (b_r[0]) begin
      mul_acc_s = acc_r + a_r;
    end else begin
      mul_acc_s = acc_r;
    end
    if (ge_s) begin
      rem_nxt_s = shifted_s[WIDTH-1:0] - b_r;
    end else begin
      rem_nxt_s = shifted_s[WIDTH-1:0];
    end
    case (op_r)
      OP_MUL:  iter_res_s = mul_acc_s;
      OP_DIVU: iter_res_s = quo_nxt_s;
      OP_REMU: iter_res_s = rem_nxt_s;
      default: iter_res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {SHW{1'b0}};
      op_r       <= 4'b0000;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      zero_r     <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            op_r       <= bus.alu_op;
            a_r        <= bus.a;
            b_r        <= bus.b;
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {SHW{1'b0}};
            div_zero_r <= is_div_s && b_zero_s;
            if (go_calc_s) begin
              busy_r <= 1'b1;
            end else begin
              result_r <= imm_res_s;
              zero_r   <= (imm_res_s == {WIDTH{1'b0}});
              done_r   <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r + SHW'(1);
          if (op_r == OP_MUL) begin
            acc_r <= mul_acc_s;
            a_r   <= {a_r[WIDTH-2:0], 1'b0};
            b_r   <= {1'b0, b_r[WIDTH-1:1]};
          end else begin
            acc_r <= rem_nxt_s;
            a_r   <= quo_nxt_s;
          end
          if (last_s) begin
            result_r <= iter_res_s;
            zero_r   <= (iter_res_s == {WIDTH{1'b0}});
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            cnt_r    <= {SHW{1'b0}};
          end
        end
        ST_DONE: done_r <= 1'b0;
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign bus.result   = result_r;
  assign bus.zero     = zero_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;

endmodule
